multiphase_signal_controller: RTL and testbench
===============================================

// Module: multiphase_signal_controller
// PURPOSE
// Parametrised N-approach signal sequencer for an intersection. Replaces fixed two-way NS/EW sequencing.
// Serves phases round-robin: GREEN -> YELLOW -> ALL_RED -> next GREEN.
// Per-phase pedestrian demand can shorten the current green and skip idle phases.
// Error and four-way-stop overrides flash all heads. Drives per-phase 2-bit light codes to the lamp/segment decoders.
// PARAMETERS
// N_PHASES    4            number of approaches, 2..8
// CNT_W       32           timer width; every time parameter must fit
// INIT_TIME   100_000_000  solid all-yellow after reset, cycles (>=1)
// GREEN_MIN   250_000_000  minimum green before a demand-driven exit (>=1, <=GREEN_MAX)
// GREEN_MAX   750_000_000  maximum green, cycles
// YELLOW_TIME 100_000_000  yellow duration, cycles (>=1)
// ALLRED_TIME 50_000_000   all-red clearance, cycles (>=1)
// FLASH_HALF  50_000_000   four-way flash half-period, cycles (>=1)
// ERR_HALF    25_000_000   error flash half-period, cycles (>=1)
// PORTS
// clk           in   1          system clock
// reset_n       in   1          asynchronous, active-low reset
// ped_req       in   N_PHASES   pedestrian buttons, async, level
// error         in   1          error override switch, async
// four_way_stop in   1          four-way-stop override switch, async
// light         out  2*N_PHASES light code per phase, bits [2i+1:2i]: 00 OFF, 01 RED, 10 YELLOW, 11 GREEN
// active_phase  out  clog2(N)   phase currently owning green/yellow/all-red
// ped_pending   out  N_PHASES   latched pedestrian demand per phase
// BEHAVIOUR
// - One clock. Reset is asynchronous and active-low.
// - Reset: state INIT, timer 0, flash 0, ped_pending 0, active_phase 0, light = all YELLOW.
//   light is decoded combinationally from registered state, so it takes this value immediately while reset_n is low.
// - ped_req, error and four_way_stop each pass a 2-FF synchroniser, giving 2 cycles of latency.
// - ped_pending[i] sets on a rising edge of synced ped_req[i].
//   It clears on the cycle the FSM enters GREEN for phase i.
//   An edge on the phase currently in GREEN is ignored (already served).
// - Override priority: error > four_way_stop > normal sequencing. Overrides are evaluated in every state, including INIT.
// - States and transitions (timer counts 0..T-1, then transitions and resets to 0):
//   INIT:    all YELLOW; after INIT_TIME -> GREEN, phase 0.
//   GREEN:   phase p GREEN, others RED.
//            -> YELLOW when timer==GREEN_MAX-1,
//            or when timer>=GREEN_MIN-1 and ped_pending has any bit j!=p set.
//   YELLOW:  phase p YELLOW, others RED; after YELLOW_TIME -> ALL_RED.
//   ALL_RED: all RED; after ALLRED_TIME -> GREEN of the next phase q.
//            q = first j with ped_pending[j]=1, scanning p+1, p+2, ... modulo N_PHASES.
//            If no demand, q = (p+1) mod N_PHASES.
//   FLASH_4W: all RED when flash=0, all OFF when flash=1; flash toggles every FLASH_HALF cycles.
//   FLASH_ERR: all YELLOW when flash=0, all OFF when flash=1; flash toggles every ERR_HALF cycles.
// - Override entry, and FLASH_4W<->FLASH_ERR switching, both reset timer=0 and flash=0.
// - Override exit (both synced switches low): -> ALL_RED with active_phase=N_PHASES-1.
//   The next green is therefore the first pending phase from 0, else phase 0.
// - ped_pending keeps latching during INIT and the flash states.
// - Timer never wraps: every state exits or reloads before reaching its limit.
// TESTING (bench params: N_PHASES=3, INIT=5, GREEN_MIN=4, GREEN_MAX=10, YELLOW=3, ALLRED=2, FLASH_HALF=4, ERR_HALF=2)
// 1. Release reset, no inputs -> all YELLOW 5 cyc; p0 GREEN 10; p0 YELLOW 3; all RED 2; p1 GREEN; cycle repeats p2, p0.
// 2. 1-cycle ped_req[2] pulse at p0 green timer=0 -> ped_pending=3'b100 two-three cycles later.
//    Then p0 YELLOW after a 4-cycle green; p1 is skipped; p2 GREEN with ped_pending cleared that cycle.
// 3. ped_req[0] pulse during p0 GREEN -> no pending bit set; p0 green lasts the full 10 cycles.
// 4. error=1 mid-green -> 2 cycles later all YELLOW/OFF toggling every 2 cycles.
//    Add four_way_stop=1 -> no change. Drop error -> all RED/OFF every 4 cycles.
//    Drop four_way_stop -> all RED 2 cycles, then p0 GREEN.
// 5. Latch ped_req[1] during FLASH_ERR, then clear overrides -> ALL_RED 2 cycles -> p1 GREEN; pending clears.
// 6. Assert reset_n=0 mid-YELLOW on p2 with ped_pending=3'b011 -> immediate all YELLOW, pending=0, active_phase=0.
//    Release reset -> test 1 sequence replays.

Source files
------------

// File: rtl/multiphase_signal_controller.sv
// N-approach round-robin signal sequencer with pedestrian demand, early green exit,
// phase skipping, and error / four-way-stop flash overrides.
module multiphase_signal_controller #(
   parameter int unsigned N_PHASES    = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned INIT_TIME   = 100_000_000,
   parameter int unsigned GREEN_MIN   = 250_000_000,
   parameter int unsigned GREEN_MAX   = 750_000_000,
   parameter int unsigned YELLOW_TIME = 100_000_000,
   parameter int unsigned ALLRED_TIME = 50_000_000,
   parameter int unsigned FLASH_HALF  = 50_000_000,
   parameter int unsigned ERR_HALF    = 25_000_000,
   localparam int unsigned PW         = $clog2(N_PHASES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_PHASES-1:0]   ped_req,
   input  logic                  error,
   input  logic                  four_way_stop,
   output logic [2*N_PHASES-1:0] light,
   output logic [PW-1:0]         active_phase,
   output logic [N_PHASES-1:0]   ped_pending
);

   typedef enum logic [2:0] {
      S_INIT, S_GREEN, S_YELLOW, S_ALL_RED, S_FLASH_4W, S_FLASH_ERR
   } state_t;

   localparam logic [1:0] L_OFF = 2'b00, L_RED = 2'b01, L_YEL = 2'b10, L_GRN = 2'b11;

   localparam logic [CNT_W-1:0] T_INIT  = CNT_W'(INIT_TIME - 1);
   localparam logic [CNT_W-1:0] T_GMIN  = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] T_GMAX  = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] T_AR    = CNT_W'(ALLRED_TIME - 1);
   localparam logic [CNT_W-1:0] T_F4W   = CNT_W'(FLASH_HALF - 1);
   localparam logic [CNT_W-1:0] T_FERR  = CNT_W'(ERR_HALF - 1);
   localparam logic [N_PHASES-1:0] ONE  = N_PHASES'(1);

   state_t              state, state_n;
   logic [CNT_W-1:0]    timer, timer_n;
   logic                flash, flash_n;
   logic [PW-1:0]       phase_n;
   logic [N_PHASES-1:0] pending_n;

   logic [N_PHASES-1:0] ped_s1, ped_s2, ped_d;
   logic                err_s1, err_s2, fws_s1, fws_s2;
   logic [N_PHASES-1:0] ped_rise, cur_mask, green_mask;
   logic                enter_green;

   // Offsets scanned high-to-low so the nearest pending phase after p wins; p itself is last.
   function automatic logic [PW-1:0] pick_next(input logic [PW-1:0] p,
                                               input logic [N_PHASES-1:0] pend);
      int unsigned idx;
      pick_next = PW'((32'(p) + 1) % N_PHASES);
      for (int unsigned k = N_PHASES; k >= 1; k--) begin
         idx = (32'(p) + k) % N_PHASES;
         if (pend[idx]) pick_next = PW'(idx);
      end
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ped_s1 <= '0;
         ped_s2 <= '0;
         ped_d  <= '0;
         err_s1 <= 1'b0;
         err_s2 <= 1'b0;
         fws_s1 <= 1'b0;
         fws_s2 <= 1'b0;
      end else begin
         ped_s1 <= ped_req;
         ped_s2 <= ped_s1;
         ped_d  <= ped_s2;
         err_s1 <= error;
         err_s2 <= err_s1;
         fws_s1 <= four_way_stop;
         fws_s2 <= fws_s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_INIT;
         timer        <= '0;
         flash        <= 1'b0;
         active_phase <= '0;
         ped_pending  <= '0;
      end else begin
         state        <= state_n;
         timer        <= timer_n;
         flash        <= flash_n;
         active_phase <= phase_n;
         ped_pending  <= pending_n;
      end
   end

   assign ped_rise   = ped_s2 & ~ped_d;
   assign cur_mask   = ONE << active_phase;
   assign green_mask = (state == S_GREEN) ? cur_mask : '0;

   always_comb begin
      state_n     = state;
      timer_n     = timer + CNT_W'(1);
      flash_n     = flash;
      phase_n     = active_phase;
      enter_green = 1'b0;
      pending_n   = ped_pending | (ped_rise & ~green_mask);

      if (err_s2) begin
         if (state != S_FLASH_ERR) begin
            state_n = S_FLASH_ERR;
            timer_n = '0;
            flash_n = 1'b0;
         end else if (timer == T_FERR) begin
            timer_n = '0;
            flash_n = ~flash;
         end
      end else if (fws_s2) begin
         if (state != S_FLASH_4W) begin
            state_n = S_FLASH_4W;
            timer_n = '0;
            flash_n = 1'b0;
         end else if (timer == T_F4W) begin
            timer_n = '0;
            flash_n = ~flash;
         end
      end else begin
         case (state)
            S_INIT: if (timer == T_INIT) begin
               state_n     = S_GREEN;
               timer_n     = '0;
               phase_n     = '0;
               enter_green = 1'b1;
            end
            S_GREEN: if (timer == T_GMAX ||
                         (timer >= T_GMIN && |(ped_pending & ~cur_mask))) begin
               state_n = S_YELLOW;
               timer_n = '0;
            end
            S_YELLOW: if (timer == T_YEL) begin
               state_n = S_ALL_RED;
               timer_n = '0;
            end
            S_ALL_RED: if (timer == T_AR) begin
               state_n     = S_GREEN;
               timer_n     = '0;
               phase_n     = pick_next(active_phase, ped_pending);
               enter_green = 1'b1;
            end
            // Parking on the last phase makes the next scan start from phase 0.
            S_FLASH_4W, S_FLASH_ERR: begin
               state_n = S_ALL_RED;
               timer_n = '0;
               flash_n = 1'b0;
               phase_n = PW'(N_PHASES - 1);
            end
            default: begin
               state_n = S_INIT;
               timer_n = '0;
            end
         endcase
      end

      if (enter_green) pending_n = pending_n & ~(ONE << phase_n);
   end

   always_comb begin
      light = '0;
      for (int unsigned i = 0; i < N_PHASES; i++) begin
         case (state)
            S_INIT:      light[2*i +: 2] = L_YEL;
            S_GREEN:     light[2*i +: 2] = (PW'(i) == active_phase) ? L_GRN : L_RED;
            S_YELLOW:    light[2*i +: 2] = (PW'(i) == active_phase) ? L_YEL : L_RED;
            S_ALL_RED:   light[2*i +: 2] = L_RED;
            S_FLASH_4W:  light[2*i +: 2] = flash ? L_OFF : L_RED;
            S_FLASH_ERR: light[2*i +: 2] = flash ? L_OFF : L_YEL;
            default:     light[2*i +: 2] = L_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_multiphase_signal_controller.sv
// Scoreboard bench: the stimulus thread queues per-cycle expected outputs,
// the monitor pops and compares one entry on every falling clock edge.
module tb_multiphase_signal_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] ped_req;
   logic       error;
   logic       four_way_stop;
   logic [5:0] light;
   logic [1:0] active_phase;
   logic [2:0] ped_pending;

   multiphase_signal_controller #(
      .N_PHASES(3), .CNT_W(8), .INIT_TIME(5), .GREEN_MIN(4), .GREEN_MAX(10),
      .YELLOW_TIME(3), .ALLRED_TIME(2), .FLASH_HALF(4), .ERR_HALF(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ped_req(ped_req), .error(error),
      .four_way_stop(four_way_stop), .light(light), .active_phase(active_phase),
      .ped_pending(ped_pending)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] ALLY = 6'b10_10_10, ALLR = 6'b01_01_01, DARK = 6'b00_00_00;
   localparam logic [5:0] G0 = 6'b01_01_11, G1 = 6'b01_11_01, G2 = 6'b11_01_01;
   localparam logic [5:0] Y0 = 6'b01_01_10, Y1 = 6'b01_10_01, Y2 = 6'b10_01_01;

   typedef struct packed {
      logic [5:0] lt;
      logic [1:0] ph;
      logic [2:0] pd;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   slot  = 0;

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (light !== e.lt) begin
            n_bad++;
            $display("FAIL light slot %0d: got %b want %b", slot, light, e.lt);
         end
         n_cmp++;
         if (active_phase !== e.ph) begin
            n_bad++;
            $display("FAIL active_phase slot %0d: got %0d want %0d", slot, active_phase, e.ph);
         end
         n_cmp++;
         if (ped_pending !== e.pd) begin
            n_bad++;
            $display("FAIL ped_pending slot %0d: got %b want %b", slot, ped_pending, e.pd);
         end
         slot++;
      end
   end

   // Each slot starts 1 time unit after a rising edge: inputs already set, expectation for this cycle.
   task automatic seg(input logic [5:0] lt, input logic [1:0] ph, input logic [2:0] pd, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.lt = lt;
         e.ph = ph;
         e.pd = pd;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_sequence();
      seg(ALLY, 0, 3'b000, 5);
      seg(G0,   0, 3'b000, 10);
      seg(Y0,   0, 3'b000, 3);
      seg(ALLR, 0, 3'b000, 2);
      seg(G1,   1, 3'b000, 10);
      seg(Y1,   1, 3'b000, 3);
      seg(ALLR, 1, 3'b000, 2);
      seg(G2,   2, 3'b000, 10);
      seg(Y2,   2, 3'b000, 3);
      seg(ALLR, 2, 3'b000, 2);
   endtask

   initial begin
      reset_n       = 1'b0;
      ped_req       = '0;
      error         = 1'b0;
      four_way_stop = 1'b0;
      @(posedge clk);
      #1;
      seg(ALLY, 0, 3'b000, 2);

      // idle round-robin
      reset_n = 1'b1;
      idle_sequence();

      // demand on phase 2 shortens green and skips phase 1
      ped_req = 3'b100;
      seg(G0, 0, 3'b000, 1);
      ped_req = 3'b000;
      seg(G0, 0, 3'b000, 2);
      seg(G0, 0, 3'b100, 1);
      seg(Y0, 0, 3'b100, 3);
      seg(ALLR, 0, 3'b100, 2);
      seg(G2, 2, 3'b000, 10);
      seg(Y2, 2, 3'b000, 3);
      seg(ALLR, 2, 3'b000, 2);

      // request for the phase already green is ignored
      ped_req = 3'b001;
      seg(G0, 0, 3'b000, 1);
      ped_req = 3'b000;
      seg(G0, 0, 3'b000, 9);
      seg(Y0, 0, 3'b000, 3);
      seg(ALLR, 0, 3'b000, 2);

      // error flash, four-way-stop underneath, then recovery
      seg(G1, 1, 3'b000, 3);
      error = 1'b1;
      seg(G1, 1, 3'b000, 3);
      four_way_stop = 1'b1;
      seg(ALLY, 1, 3'b000, 2);
      seg(DARK, 1, 3'b000, 2);
      error = 1'b0;
      seg(ALLY, 1, 3'b000, 2);
      seg(DARK, 1, 3'b000, 1);
      seg(ALLR, 1, 3'b000, 2);
      four_way_stop = 1'b0;
      seg(ALLR, 1, 3'b000, 2);
      seg(DARK, 1, 3'b000, 1);
      seg(ALLR, 2, 3'b000, 2);

      // demand latched during error flash selects the first green after exit
      error = 1'b1;
      seg(G0, 0, 3'b000, 3);
      ped_req = 3'b010;
      seg(ALLY, 0, 3'b000, 1);
      ped_req = 3'b000;
      seg(ALLY, 0, 3'b000, 1);
      error = 1'b0;
      seg(DARK, 0, 3'b000, 1);
      seg(DARK, 0, 3'b010, 1);
      seg(ALLY, 0, 3'b010, 1);
      seg(ALLR, 2, 3'b010, 2);
      seg(G1, 1, 3'b000, 10);
      seg(Y1, 1, 3'b000, 3);
      seg(ALLR, 1, 3'b000, 2);

      // asynchronous reset mid-yellow with demand pending
      ped_req = 3'b011;
      seg(G2, 2, 3'b000, 1);
      ped_req = 3'b000;
      seg(G2, 2, 3'b000, 2);
      seg(G2, 2, 3'b011, 1);
      seg(Y2, 2, 3'b011, 1);
      reset_n = 1'b0;
      seg(ALLY, 0, 3'b000, 2);
      reset_n = 1'b1;
      idle_sequence();
      seg(G0, 0, 3'b000, 3);

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
